// File: rtl/dmem_arbiter_if.sv
// One requester's port on the data-memory arbiter: the request handshake and the response
// channel that returns to it.
interface dmem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one pipelined single-port data memory between two requesters.
// Responses are routed back to their issuer in acceptance order, MEM_LAT cycles after acceptance.
module dmem_arbiter #(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    io_req0,
  dmem_arbiter_if.slave    io_req1,
  output logic             o_mem_we,
  output logic [XLEN-1:0]  o_mem_addr,
  output logic [XLEN-1:0]  o_mem_wdata,
  input  logic [XLEN-1:0]  i_mem_rdata,
  output logic [CNT_W-1:0] o_grant_cnt0,
  output logic [CNT_W-1:0] o_grant_cnt1
);

  typedef enum logic {
    LAST_R0 = 1'b0,
    LAST_R1 = 1'b1
  } last_e;

  typedef struct packed {
    logic valid;
    logic owner;
    logic is_write;
  } trk_t;

  localparam trk_t TRK_IDLE = '{valid: 1'b0, owner: 1'b0, is_write: 1'b0};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  last_e            r_last;
  last_e            w_last_nxt;
  logic             w_gnt0;
  logic             w_gnt1;
  trk_t             w_new;
  trk_t             w_exit;
  logic             w_rsp0;
  logic             w_rsp1;
  trk_t             r_trk [MEM_LAT];
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Last-grant state; after reset requester 1 counts as last so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= LAST_R1;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  // Grant selection and next last-grant; grant implies acceptance because ready == grant.
  always_comb begin
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_last_nxt = r_last;
    if (reset) begin
      case ({io_req0.valid, io_req1.valid})
        2'b10: w_gnt0 = 1'b1;
        2'b01: w_gnt1 = 1'b1;
        2'b11: begin
          if (r_last == LAST_R1) begin
            w_gnt0 = 1'b1;
          end else begin
            w_gnt1 = 1'b1;
          end
        end
        default: begin
          w_gnt0 = 1'b0;
          w_gnt1 = 1'b0;
        end
      endcase
      if (w_gnt0) begin
        w_last_nxt = LAST_R0;
      end else if (w_gnt1) begin
        w_last_nxt = LAST_R1;
      end else begin
        w_last_nxt = r_last;
      end
    end else begin
      w_gnt0     = 1'b0;
      w_gnt1     = 1'b0;
      w_last_nxt = r_last;
    end
  end

  assign io_req0.ready = w_gnt0;
  assign io_req1.ready = w_gnt1;

  // Memory bus follows the granted requester and is parked at zero when idle.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = {XLEN{1'b0}};
    o_mem_wdata = {XLEN{1'b0}};
    if (w_gnt0) begin
      o_mem_we    = io_req0.we;
      o_mem_addr  = io_req0.addr;
      o_mem_wdata = io_req0.wdata;
    end else if (w_gnt1) begin
      o_mem_we    = io_req1.we;
      o_mem_addr  = io_req1.addr;
      o_mem_wdata = io_req1.wdata;
    end else begin
      o_mem_we    = 1'b0;
      o_mem_addr  = {XLEN{1'b0}};
      o_mem_wdata = {XLEN{1'b0}};
    end
  end

  assign w_new = '{valid: w_gnt0 | w_gnt1, owner: w_gnt1, is_write: o_mem_we};

  // In-flight tracker; its length matches the memory latency so the exiting entry lines up with rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        r_trk[i] <= TRK_IDLE;
      end
    end else begin
      r_trk[0] <= w_new;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_trk[i] <= r_trk[i-1];
      end
    end
  end

  assign w_exit = r_trk[MEM_LAT-1];
  assign w_rsp0 = w_exit.valid && (w_exit.owner == 1'b0);
  assign w_rsp1 = w_exit.valid && (w_exit.owner == 1'b1);

  assign io_req0.rsp_valid = w_rsp0;
  assign io_req1.rsp_valid = w_rsp1;
  assign io_req0.rsp_rdata = (w_rsp0 && !w_exit.is_write) ? i_mem_rdata : {XLEN{1'b0}};
  assign io_req1.rsp_rdata = (w_rsp1 && !w_exit.is_write) ? i_mem_rdata : {XLEN{1'b0}};

  // Saturating per-requester acceptance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt0 <= {CNT_W{1'b0}};
      r_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (w_gnt0) begin
        r_cnt0 <= sat_inc(r_cnt0);
      end
      if (w_gnt1) begin
        r_cnt1 <= sat_inc(r_cnt1);
      end
    end
  end

  assign o_grant_cnt0 = r_cnt0;
  assign o_grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT=1/CNT_W=4 and MEM_LAT=3/CNT_W=16) share one
// stimulus stream; a reference arbiter and a response scoreboard check both.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int XLEN  = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int CW_A  = 4;
  localparam int CW_B  = 16;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus
  logic        v0, we0, v1, we1;
  logic [31:0] ad0, wd0, ad1, wd1;

  dmem_arbiter_if #(.XLEN(XLEN)) a0 ();
  dmem_arbiter_if #(.XLEN(XLEN)) a1 ();
  dmem_arbiter_if #(.XLEN(XLEN)) b0 ();
  dmem_arbiter_if #(.XLEN(XLEN)) b1 ();

  assign a0.valid = v0;  assign a0.we = we0;  assign a0.addr = ad0;  assign a0.wdata = wd0;
  assign a1.valid = v1;  assign a1.we = we1;  assign a1.addr = ad1;  assign a1.wdata = wd1;
  assign b0.valid = v0;  assign b0.we = we0;  assign b0.addr = ad0;  assign b0.wdata = wd0;
  assign b1.valid = v1;  assign b1.we = we1;  assign b1.addr = ad1;  assign b1.wdata = wd1;

  logic            a_mem_we, b_mem_we;
  logic [31:0]     a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [31:0]     b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [CW_A-1:0] a_cnt0, a_cnt1;
  logic [CW_B-1:0] b_cnt0, b_cnt1;

  dmem_arbiter #(.XLEN(XLEN), .MEM_LAT(LAT_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset(reset), .io_req0(a0.slave), .io_req1(a1.slave),
    .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
    .i_mem_rdata(a_mem_rdata), .o_grant_cnt0(a_cnt0), .o_grant_cnt1(a_cnt1)
  );

  dmem_arbiter #(.XLEN(XLEN), .MEM_LAT(LAT_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset), .io_req0(b0.slave), .io_req1(b1.slave),
    .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .i_mem_rdata(b_mem_rdata), .o_grant_cnt0(b_cnt0), .o_grant_cnt1(b_cnt1)
  );

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'hCAFE_0001;
    return 32'hD000_0000 ^ (32'(idx) * 32'h0001_0103);
  endfunction

  // memories: unwritten words read back their init_word pattern
  logic [31:0]  mem_a [0:255];
  logic [31:0]  mem_b [0:255];
  logic [255:0] wr_a = '0;
  logic [255:0] wr_b = '0;
  logic [31:0]  rp_a [LAT_A];
  logic [31:0]  rp_b [LAT_B];

  function automatic logic [31:0] mem_rd_a(input int idx);
    return wr_a[idx] ? mem_a[idx] : init_word(idx);
  endfunction
  function automatic logic [31:0] mem_rd_b(input int idx);
    return wr_b[idx] ? mem_b[idx] : init_word(idx);
  endfunction

  always @(posedge clk) begin
    if (a_mem_we) begin
      mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
      wr_a[a_mem_addr[9:2]]  <= 1'b1;
    end
    rp_a[0] <= mem_rd_a(int'(a_mem_addr[9:2]));
  end
  assign a_mem_rdata = rp_a[LAT_A-1];

  always @(posedge clk) begin
    if (b_mem_we) begin
      mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
      wr_b[b_mem_addr[9:2]]  <= 1'b1;
    end
    rp_b[0] <= mem_rd_b(int'(b_mem_addr[9:2]));
    for (int k = 1; k < LAT_B; k++) rp_b[k] <= rp_b[k-1];
  end
  assign b_mem_rdata = rp_b[LAT_B-1];

  // reference memory, updated when a write is accepted
  logic [31:0]  ref_mem [0:255];
  logic [255:0] ref_wr = '0;
  function automatic logic [31:0] ref_rd(input logic [31:0] addr);
    return ref_wr[addr[9:2]] ? ref_mem[addr[9:2]] : init_word(int'(addr[9:2]));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  exp_t sb_qa[$];
  exp_t sb_qb[$];

  task automatic sb_push(input int k, input exp_t e);
    if (k == 0) sb_qa.push_back(e); else sb_qb.push_back(e);
  endtask
  task automatic sb_pop(input int k, output exp_t e);
    if (k == 0) e = sb_qa.pop_front(); else e = sb_qb.pop_front();
  endtask
  function automatic int sb_size(input int k);
    return (k == 0) ? sb_qa.size() : sb_qb.size();
  endfunction
  function automatic int sb_due(input int k);
    return (k == 0) ? sb_qa[0].due : sb_qb[0].due;
  endfunction

  task automatic sb_step(input int k, input int lat, input logic rv0, input logic rv1,
                         input logic [31:0] rd0, input logic [31:0] rd1,
                         input logic rdy0, input logic rdy1);
    exp_t e;
    logic due_now;
    due_now = (sb_size(k) > 0) && (sb_due(k) <= cyc);
    chk((k == 0) ? "rsp_valid_A" : "rsp_valid_B", 64'(rv0 | rv1), 64'(due_now));
    chk("rsp_excl", 64'(rv0 & rv1), 64'd0);
    if ((rv0 || rv1 || due_now) && sb_size(k) > 0) begin
      sb_pop(k, e);
      chk("rsp_owner", 64'(rv1), 64'(e.owner));
      chk("rsp_rdata", 64'(e.owner ? rd1 : rd0), 64'(e.data));
      chk("rsp_other_rdata", 64'(e.owner ? rd0 : rd1), 64'd0);
    end
    if (rdy0 && v0) begin
      e.owner = 1'b0; e.data = we0 ? 32'h0 : ref_rd(ad0); e.due = cyc + lat;
      sb_push(k, e);
      if (we0) begin ref_mem[ad0[9:2]] = wd0; ref_wr[ad0[9:2]] = 1'b1; end
    end
    if (rdy1 && v1) begin
      e.owner = 1'b1; e.data = we1 ? 32'h0 : ref_rd(ad1); e.due = cyc + lat;
      sb_push(k, e);
      if (we1) begin ref_mem[ad1[9:2]] = wd1; ref_wr[ad1[9:2]] = 1'b1; end
    end
  endtask

  // response monitor for both instances
  always @(negedge clk) begin
    if (reset) begin
      sb_step(0, LAT_A, a0.rsp_valid, a1.rsp_valid, a0.rsp_rdata, a1.rsp_rdata, a0.ready, a1.ready);
      sb_step(1, LAT_B, b0.rsp_valid, b1.rsp_valid, b0.rsp_rdata, b1.rsp_rdata, b0.ready, b1.ready);
    end
  end

  // reference arbiter state
  logic lg_m = 1'b1;
  logic g0_m, g1_m;
  int   cnt0_m = 0;
  int   cnt1_m = 0;

  task automatic cycle_check();
    logic [31:0] ea, ed;
    logic        ew;
    g0_m = v0 && (!v1 || lg_m);
    g1_m = v1 && (!v0 || !lg_m);
    ea = g0_m ? ad0 : (g1_m ? ad1 : 32'h0);
    ed = g0_m ? wd0 : (g1_m ? wd1 : 32'h0);
    ew = (g0_m && we0) || (g1_m && we1);
    chk("gnt0_A", 64'(a0.ready), 64'(g0_m));
    chk("gnt1_A", 64'(a1.ready), 64'(g1_m));
    chk("gnt0_B", 64'(b0.ready), 64'(g0_m));
    chk("gnt1_B", 64'(b1.ready), 64'(g1_m));
    chk("mem_we_A", 64'(a_mem_we), 64'(ew));
    chk("mem_addr_A", 64'(a_mem_addr), 64'(ea));
    chk("mem_wdata_A", 64'(a_mem_wdata), 64'(ed));
    chk("mem_we_B", 64'(b_mem_we), 64'(ew));
    chk("mem_addr_B", 64'(b_mem_addr), 64'(ea));
    chk("cnt0_A", 64'(a_cnt0), 64'((cnt0_m > 15) ? 15 : cnt0_m));
    chk("cnt1_A", 64'(a_cnt1), 64'((cnt1_m > 15) ? 15 : cnt1_m));
    chk("cnt0_B", 64'(b_cnt0), 64'((cnt0_m > 65535) ? 65535 : cnt0_m));
    chk("cnt1_B", 64'(b_cnt1), 64'((cnt1_m > 65535) ? 65535 : cnt1_m));
    if (g0_m) begin lg_m = 1'b0; cnt0_m++; end
    else if (g1_m) begin lg_m = 1'b1; cnt1_m++; end
  endtask

  task automatic at_neg(); @(negedge clk); cycle_check(); endtask
  task automatic to_pos(); @(posedge clk); #1; endtask
  task automatic step();   at_neg(); to_pos(); endtask

  task automatic set_idle();
    v0 = 1'b0; we0 = 1'b0; ad0 = 32'h0; wd0 = 32'h0;
    v1 = 1'b0; we1 = 1'b0; ad1 = 32'h0; wd1 = 32'h0;
  endtask

  // called just after a rising edge; checks the asynchronous effect of reset
  task automatic apply_reset();
    reset = 1'b0;
    sb_qa.delete();
    sb_qb.delete();
    #1;
    chk("rst_rsp0_v_A", 64'(a0.rsp_valid), 64'd0);
    chk("rst_rsp1_v_A", 64'(a1.rsp_valid), 64'd0);
    chk("rst_rsp0_v_B", 64'(b0.rsp_valid), 64'd0);
    chk("rst_rsp1_v_B", 64'(b1.rsp_valid), 64'd0);
    chk("rst_rsp0_rd_B", 64'(b0.rsp_rdata), 64'd0);
    chk("rst_cnt0_A", 64'(a_cnt0), 64'd0);
    chk("rst_cnt1_B", 64'(b_cnt1), 64'd0);
    v0 = 1'b1; v1 = 1'b1; we0 = 1'b1;
    #1;
    chk("rst_ready0_A", 64'(a0.ready), 64'd0);
    chk("rst_ready1_A", 64'(a1.ready), 64'd0);
    chk("rst_ready0_B", 64'(b0.ready), 64'd0);
    chk("rst_mem_we_A", 64'(a_mem_we), 64'd0);
    set_idle();
    lg_m = 1'b1; cnt0_m = 0; cnt1_m = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // T1: single read returns one cycle later on the LAT=1 instance
    v0 = 1'b1; ad0 = 32'h10;
    at_neg(); chk("T1_ready0", 64'(a0.ready), 64'd1); to_pos();
    set_idle();
    at_neg();
    chk("T1_rsp0_v", 64'(a0.rsp_valid), 64'd1);
    chk("T1_rsp0_rd", 64'(a0.rsp_rdata), 64'hCAFE_0001);
    chk("T1_rsp1_v", 64'(a1.rsp_valid), 64'd0);
    to_pos();

    // T2: continuous tie from reset alternates starting with requester 0
    apply_reset();
    v0 = 1'b1; ad0 = 32'h40; v1 = 1'b1; ad1 = 32'h80;
    for (int i = 0; i < 6; i++) begin
      at_neg(); chk("T2_order", 64'(a0.ready), 64'((i % 2) == 0)); to_pos();
    end
    set_idle();
    at_neg();
    chk("T2_cnt0", 64'(a_cnt0), 64'd3);
    chk("T2_cnt1", 64'(a_cnt1), 64'd3);
    to_pos();

    // T3: write from requester 1, acknowledged with zero data, then read back
    v1 = 1'b1; we1 = 1'b1; ad1 = 32'h20; wd1 = 32'h1234_5678;
    at_neg(); chk("T3_we_on", 64'(a_mem_we), 64'd1); to_pos();
    set_idle();
    at_neg();
    chk("T3_we_off", 64'(a_mem_we), 64'd0);
    chk("T3_rsp1_v", 64'(a1.rsp_valid), 64'd1);
    chk("T3_rsp1_rd", 64'(a1.rsp_rdata), 64'd0);
    chk("T3_mem", 64'(mem_rd_a(8)), 64'h1234_5678);
    to_pos();
    v0 = 1'b1; ad0 = 32'h20;
    step();
    set_idle();
    step();

    // T4: r0, r1, r0 accepted back to back on the LAT=3 instance
    v0 = 1'b1; ad0 = 32'h100; step(); set_idle();
    v1 = 1'b1; ad1 = 32'h104; step(); set_idle();
    v0 = 1'b1; ad0 = 32'h108; step(); set_idle();
    for (int j = 3; j <= 6; j++) begin
      at_neg();
      chk("T4_rsp0_v", 64'(b0.rsp_valid), 64'((j == 3) || (j == 5)));
      chk("T4_rsp1_v", 64'(b1.rsp_valid), 64'(j == 4));
      if (j == 3) chk("T4_dataA", 64'(b0.rsp_rdata), 64'(init_word(64)));
      if (j == 4) chk("T4_dataB", 64'(b1.rsp_rdata), 64'(init_word(65)));
      if (j == 5) chk("T4_dataC", 64'(b0.rsp_rdata), 64'(init_word(66)));
      to_pos();
    end

    // T5: reset while two responses are in flight on the LAT=3 instance
    v0 = 1'b1; ad0 = 32'h104; step(); set_idle();
    v1 = 1'b1; ad1 = 32'h108; step(); set_idle();
    step();
    chk("T5_pre_rsp0", 64'(b0.rsp_valid), 64'd1);
    apply_reset();
    for (int j = 0; j < 6; j++) begin
      at_neg();
      chk("T5_no_rsp0", 64'(b0.rsp_valid), 64'd0);
      chk("T5_no_rsp1", 64'(b1.rsp_valid), 64'd0);
      to_pos();
    end
    v0 = 1'b1; ad0 = 32'h40; v1 = 1'b1; ad1 = 32'h44;
    at_neg(); chk("T5_tie_A", 64'(a0.ready), 64'd1); chk("T5_tie_B", 64'(b0.ready), 64'd1); to_pos();
    set_idle();

    // T6: 20 requester-0 transfers saturate the 4-bit counter
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      v0 = 1'b1; we0 = i[0]; ad0 = 32'h40 + 32'(i % 8) * 32'd4; wd0 = 32'(i) ^ 32'h5A5A_0000;
      step();
    end
    set_idle();
    at_neg();
    chk("T6_cnt0_A", 64'(a_cnt0), 64'd15);
    chk("T6_cnt1_A", 64'(a_cnt1), 64'd0);
    chk("T6_cnt0_B", 64'(b_cnt0), 64'd20);
    to_pos();
    repeat (2) step();

    // random traffic; each request is held until the reference arbiter grants it
    for (int i = 0; i < 200; i++) begin
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        ad0 = 32'h40 + 32'($urandom_range(0, 15)) * 32'd4; wd0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        ad1 = 32'h40 + 32'($urandom_range(0, 15)) * 32'd4; wd1 = $urandom;
      end
      step();
      if (g0_m) v0 = 1'b0;
      if (g1_m) v1 = 1'b0;
    end
    set_idle();
    repeat (LAT_B + 2) step();
    chk("drain_A", 64'(sb_qa.size()), 64'd0);
    chk("drain_B", 64'(sb_qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
